// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices, each built from 4-bit CLA groups.
// Define CLA_SATURATE_EN to clamp the result to the signed range on overflow.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / 4;

    // One slice: per-group generate/propagate, group-level lookahead, in-group expanded carries.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                              input logic c0);
        logic [SW-1:0] g, p, c;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        int            o;
        g = a & b;
        p = a | b;
        for (int j = 0; j < NG; j++) begin
            o = 4 * j;
            gg[j] = g[o+3] | (p[o+3] & g[o+2]) | (p[o+3] & p[o+2] & g[o+1])
                  | (p[o+3] & p[o+2] & p[o+1] & g[o]);
            gp[j] = &p[o +: 4];
        end
        gc[0] = c0;
        for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < NG; j++) begin
            o = 4 * j;
            c[o]   = gc[j];
            c[o+1] = g[o] | (p[o] & gc[j]);
            c[o+2] = g[o+1] | (p[o+1] & g[o]) | (p[o+1] & p[o] & gc[j]);
            c[o+3] = g[o+2] | (p[o+2] & g[o+1]) | (p[o+2] & p[o+1] & g[o])
                   | (p[o+2] & p[o+1] & p[o] & gc[j]);
        end
        return {gc[NG], a ^ b ^ c};
    endfunction

    // Stage inputs: operands are kept right-aligned so each stage consumes the low SW bits.
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_res [STAGES];
    logic             st_c   [STAGES];
    logic             st_sub [STAGES];
    logic             st_v   [STAGES];

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovfl_q, zero_q, neg_q;
    logic             advance;

    assign in_ready = !out_valid_q || out_ready;
    assign advance  = in_ready;

    assign st_a[0]   = A;
    assign st_b[0]   = B;
    assign st_res[0] = '0;
    assign st_c[0]   = sub | cin;
    assign st_sub[0] = sub;
    assign st_v[0]   = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    bx;
        logic [SW:0]      sl;
        logic [WIDTH-1:0] res_d;

        assign bx    = st_b[k][SW-1:0] ^ {SW{st_sub[k]}};
        assign sl    = cla_slice(st_a[k][SW-1:0], bx, st_c[k]);
        // New slice enters at the top; finished low bits shift down.
        assign res_d = (st_res[k] >> SW) | (WIDTH'(sl[SW-1:0]) << (WIDTH - SW));

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q, b_q, res_q;
            logic             c_q, sub_q, v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    res_q <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                end else if (advance) begin
                    v_q   <= st_v[k];
                    a_q   <= st_a[k] >> SW;
                    b_q   <= st_b[k] >> SW;
                    res_q <= res_d;
                    c_q   <= sl[SW];
                    sub_q <= st_sub[k];
                end
            end

            assign st_a[k+1]   = a_q;
            assign st_b[k+1]   = b_q;
            assign st_res[k+1] = res_q;
            assign st_c[k+1]   = c_q;
            assign st_sub[k+1] = sub_q;
            assign st_v[k+1]   = v_q;
        end else begin : g_last
            logic             sa, ovfl_d;
            logic [WIDTH-1:0] s_d;

            always_comb begin
                sa     = st_a[k][SW-1];
                ovfl_d = (sa == bx[SW-1]) && (sl[SW-1] != sa);
                s_d    = res_d;
`ifdef CLA_SATURATE_EN
                if (ovfl_d) begin
                    s_d = sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    s_q         <= '0;
                    cout_q      <= 1'b0;
                    ovfl_q      <= 1'b0;
                    zero_q      <= 1'b0;
                    neg_q       <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= st_v[k];
                    if (st_v[k]) begin
                        s_q    <= s_d;
                        cout_q <= sl[SW];
                        ovfl_q <= ovfl_d;
                        zero_q <= (s_d == '0);
                        neg_q  <= s_d[WIDTH-1];
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign cout      = cout_q;
    assign ovfl      = ovfl_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder at WIDTH=16, STAGES=2.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic [15:0] A, B, S;
    logic        cout, ovfl, zero, neg;

    int checks   = 0;
    int failures = 0;

    pipelined_cla_adder #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(S),
        .cout(cout), .ovfl(ovfl), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        cout, ovfl;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference sum with optional saturation; returns {cout, ovfl, s}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic sb);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ov;
        logic [15:0] s;
        bb   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (sb ? 1'b1 : c)};
        ov   = (a[15] == bb[15]) && (full[15] != a[15]);
        s    = full[15:0];
`ifdef CLA_SATURATE_EN
        if (ov) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {full[16], ov, s};
    endfunction

    function automatic logic [15:0] sat_s(input vec_t v);
        logic [15:0] s;
        s = v.s;
`ifdef CLA_SATURATE_EN
        if (v.ovfl) s = v.a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return s;
    endfunction

    logic [15:0] sa_q[4], sb_q[4];
    logic [17:0] exp_q[4];
    logic [17:0] m;
    logic [15:0] es;
    int sent, got, hold, seen_low, n;

    initial begin
        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[8]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[9]  = '{16'h00F0, 16'h0010, 1'b1, 1'b1, 16'h00E0, 1'b1, 1'b0};
        vecs[10] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0};
        vecs[11] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", S, 0);
        chk("rst_flags", {cout, ovfl, zero, neg}, 0);
        rst = 1'b0; out_ready = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Single beats: latency and function
        foreach (vecs[i]) begin
            A = vecs[i].a; B = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1", i), out_valid, 0);
            tick();
            es = sat_s(vecs[i]);
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_s", i), S, es);
            chk($sformatf("v%0d_cout", i), cout, vecs[i].cout);
            chk($sformatf("v%0d_ovfl", i), ovfl, vecs[i].ovfl);
            chk($sformatf("v%0d_zero", i), zero, es == 16'h0);
            chk($sformatf("v%0d_neg", i), neg, es[15]);
        end
        tick();

        // Streaming: 10 beats, out_ready high, no bubbles
        sub = 1'b0; cin = 1'b0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            A = 16'(c * 16'h1357);
            B = 16'(c * 16'h0F0F + 3);
            tick();
            n = c + 1;
            chk($sformatf("str_valid_c%0d", n), out_valid, (n >= 2 && n <= 11));
            if (n >= 2 && n <= 11) begin
                m = model(16'((n - 2) * 16'h1357), 16'((n - 2) * 16'h0F0F + 3), 1'b0, 1'b0);
                chk($sformatf("str_s_c%0d", n), {cout, S}, {m[17], m[15:0]});
            end
        end

        // Back-pressure: 4 beats, output held for 3 cycles
        for (int i = 0; i < 4; i++) begin
            sa_q[i] = 16'h1111 * 16'(i + 1);
            sb_q[i] = 16'h0F0F + 16'(i);
            exp_q[i] = model(sa_q[i], sb_q[i], 1'b0, 1'b1);
        end
        sub = 1'b1; sent = 0; got = 0; hold = 0; seen_low = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            in_valid  = (sent < 4);
            A         = sa_q[sent % 4];
            B         = sb_q[sent % 4];
            out_ready = (hold >= 3);
            #1;
            if (!in_ready) seen_low = 1;
            if (out_valid && !out_ready) begin
                chk($sformatf("hold_s_%0d", hold), S, exp_q[got][15:0]);
                chk($sformatf("hold_in_ready_%0d", hold), in_ready, 0);
                hold++;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_res_%0d", got), {cout, ovfl, S}, exp_q[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        chk("bp_count", got, 4);
        chk("bp_in_ready_dropped", seen_low, 1);

        // Reset with beats in flight
        in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
        tick(); tick();
        out_ready = 1'b0;
        A = 16'h0101; B = 16'h0202; in_valid = 1'b1;
        tick();
        A = 16'h0303;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_s", S, 0);
        chk("mid_rst_flags", {cout, ovfl, zero, neg}, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("mid_rst_in_ready", in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("post_rst_quiet_%0d", c), out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
